alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 84 ++++++++
 tb/tb_alu_result_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry skid FIFO between ALU and writeback, with PSW update on pop and error trap.
// Optional `ALU_RESULT_BYPASS_EN exposes the youngest buffered entry on byp_* ports.
`ifndef WORD_LENGTH
`define WORD_LENGTH 24
`endif
module alu_result_stage (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:`WORD_LENGTH-1] r,
  input  logic                    c,
  input  logic                    n,
  input  logic                    z,
  input  logic                    err,
  input  logic [4:0]              in_dest,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [0:`WORD_LENGTH-1] out_r,
  output logic [4:0]              out_dest,
  input  logic                    out_ready,
  output logic                    psw_c,
  output logic                    psw_n,
  output logic                    psw_z,
  output logic                    trap,
  output logic [4:0]              trap_dest
`ifdef ALU_RESULT_BYPASS_EN
  ,
  output logic                    byp_valid,
  output logic [4:0]              byp_dest,
  output logic [0:`WORD_LENGTH-1] byp_r
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [0:`WORD_LENGTH-1] r;
    logic                    c;
    logic                    n;
    logic                    z;
    logic [4:0]              dest;
  } entry_t;
  state_t state, nxt;
  entry_t e0, e1, new_e;
  logic accept, push, pop;
  assign new_e = '{r: r, c: c, n: n, z: z, dest: in_dest};
  assign accept = in_valid && in_ready;
  assign push = accept && !err && !flush;
  assign pop = out_valid && out_ready && !flush;
  assign out_valid = state != EMPTY;
  assign out_r = out_valid ? e0.r : '0;
  assign out_dest = out_valid ? e0.dest : '0;
  always_comb
    nxt = flush ? EMPTY :
          (push && !pop) ? (state == EMPTY ? ONE : TWO) :
          (pop && !push) ? (state == TWO ? ONE : EMPTY) : state;
  // e0 is always the head; e1 only holds the second entry while in TWO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      in_ready <= 1'b0;
      e0 <= '0;
      e1 <= '0;
      psw_c <= 1'b0;
      psw_n <= 1'b0;
      psw_z <= 1'b0;
      trap <= 1'b0;
      trap_dest <= '0;
    end else begin
      state <= nxt;
      in_ready <= nxt != TWO;
      trap <= accept && err;
      if (accept && err) trap_dest <= in_dest;
      if (pop) {psw_c, psw_n, psw_z} <= {e0.c, e0.n, e0.z};
      if ((push && state == EMPTY) || (push && pop && state == ONE)) e0 <= new_e;
      else if (pop && state == TWO) e0 <= e1;
      if (push && !pop && state == ONE) e1 <= new_e;
    end
  end
`ifdef ALU_RESULT_BYPASS_EN
  assign byp_valid = state != EMPTY;
  assign byp_dest = state == TWO ? e1.dest : state == ONE ? e0.dest : '0;
  assign byp_r = state == TWO ? e1.r : state == ONE ? e0.r : '0;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed self-checking bench for alu_result_stage.
`ifndef WORD_LENGTH
`define WORD_LENGTH 24
`endif
module tb_alu_result_stage;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_ready;
  logic [0:`WORD_LENGTH-1] r = '0, out_r;
  logic c = 1'b0, n = 1'b0, z = 1'b0, err = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [4:0] in_dest = '0, out_dest, trap_dest;
  logic out_valid, psw_c, psw_n, psw_z, trap;
`ifdef ALU_RESULT_BYPASS_EN
  logic byp_valid;
  logic [4:0] byp_dest;
  logic [0:`WORD_LENGTH-1] byp_r;
`endif
  int checks = 0, errors = 0;

  alu_result_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r(r), .c(c), .n(n), .z(z), .err(err), .in_dest(in_dest), .flush(flush),
    .out_valid(out_valid), .out_r(out_r), .out_dest(out_dest), .out_ready(out_ready),
    .psw_c(psw_c), .psw_n(psw_n), .psw_z(psw_z), .trap(trap), .trap_dest(trap_dest)
`ifdef ALU_RESULT_BYPASS_EN
    , .byp_valid(byp_valid), .byp_dest(byp_dest), .byp_r(byp_r)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [`WORD_LENGTH-1:0] rr, input logic cc, nn, zz, ee, input logic [4:0] d);
    in_valid = v; r = rr; c = cc; n = nn; z = zz; err = ee; in_dest = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_r !== 24'h0 || out_dest !== 5'd0) begin errors++; $display("FAIL rst_out_data got %h/%0d exp 0/0", out_r, out_dest); end
    checks++; if ({psw_c, psw_n, psw_z, trap} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b exp 0000", {psw_c, psw_n, psw_z, trap}); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_release_pre got %b exp 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_post got %b exp 1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1, 24'h001000, 0, 0, 0, 0, 5'd3);
    step();
    drive(0, 24'h0, 0, 0, 0, 0, 5'd0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (out_r !== 24'h001000) begin errors++; $display("FAIL single_r got %h exp 001000", out_r); end
    checks++; if (out_dest !== 5'd3) begin errors++; $display("FAIL single_dest got %0d exp 3", out_dest); end
    step();
    checks++; if (out_valid !== 1'b0 || out_r !== 24'h0 || out_dest !== 5'd0) begin errors++; $display("FAIL single_drain got %b/%h/%0d exp 0/0/0", out_valid, out_r, out_dest); end
    checks++; if ({psw_c, psw_n, psw_z} !== 3'b000) begin errors++; $display("FAIL single_psw got %b exp 000", {psw_c, psw_n, psw_z}); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1, 24'h000111, 0, 0, 0, 0, 5'd1);
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %b exp 1", in_ready); end
    drive(1, 24'h000222, 0, 0, 0, 0, 5'd2);
    step();
    drive(0, 24'h0, 0, 0, 0, 0, 5'd0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_two got %b exp 0", in_ready); end
    checks++; if (out_dest !== 5'd1 || out_r !== 24'h000111) begin errors++; $display("FAIL bp_head got %0d/%h exp 1/000111", out_dest, out_r); end
`ifdef ALU_RESULT_BYPASS_EN
    checks++; if (byp_valid !== 1'b1 || byp_dest !== 5'd2 || byp_r !== 24'h000222) begin errors++; $display("FAIL bp_bypass got %b/%0d/%h exp 1/2/000222", byp_valid, byp_dest, byp_r); end
`endif
    step();
    checks++; if (out_dest !== 5'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable got %b/%0d exp 1/1", out_valid, out_dest); end
    out_ready = 1'b1;
    step();
    checks++; if (out_dest !== 5'd2 || out_r !== 24'h000222) begin errors++; $display("FAIL bp_second got %0d/%h exp 2/000222", out_dest, out_r); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_flags();
    out_ready = 1'b1;
    drive(1, 24'h000000, 0, 0, 1, 0, 5'd4);
    step();
    drive(1, 24'hFFFFFF, 0, 1, 0, 0, 5'd5);
    step();
    drive(0, 24'h0, 0, 0, 0, 0, 5'd0);
    checks++; if ({psw_n, psw_z} !== 2'b01) begin errors++; $display("FAIL flags_first got n%b z%b exp n0 z1", psw_n, psw_z); end
    checks++; if (out_dest !== 5'd5 || out_r !== 24'hFFFFFF) begin errors++; $display("FAIL flags_pushpop got %0d/%h exp 5/FFFFFF", out_dest, out_r); end
    step();
    checks++; if ({psw_c, psw_n, psw_z} !== 3'b010) begin errors++; $display("FAIL flags_second got %b exp 010", {psw_c, psw_n, psw_z}); end
  endtask

  task automatic test_error();
    out_ready = 1'b1;
    drive(1, 24'h123456, 1, 0, 1, 1, 5'd7);
    step();
    drive(0, 24'h0, 0, 0, 0, 0, 5'd0);
    checks++; if (trap !== 1'b1 || trap_dest !== 5'd7) begin errors++; $display("FAIL err_trap got %b/%0d exp 1/7", trap, trap_dest); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL err_not_queued got %b exp 0", out_valid); end
    step();
    checks++; if (trap !== 1'b0) begin errors++; $display("FAIL err_pulse got %b exp 0", trap); end
    checks++; if ({psw_c, psw_n, psw_z} !== 3'b010) begin errors++; $display("FAIL err_psw got %b exp 010", {psw_c, psw_n, psw_z}); end
  endtask

  task automatic test_back_to_back();
    drive(1, 24'h0, 0, 0, 0, 1, 5'd9);
    step();
    drive(1, 24'h0, 0, 0, 0, 1, 5'd10);
    checks++; if (trap !== 1'b1 || trap_dest !== 5'd9) begin errors++; $display("FAIL b2b_first got %b/%0d exp 1/9", trap, trap_dest); end
    step();
    drive(0, 24'h0, 0, 0, 0, 0, 5'd0);
    checks++; if (trap !== 1'b1 || trap_dest !== 5'd10) begin errors++; $display("FAIL b2b_second got %b/%0d exp 1/10", trap, trap_dest); end
    step();
    checks++; if (trap !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", trap); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1, 24'hAAAAAA, 1, 0, 0, 0, 5'd20);
    step();
    drive(1, 24'hBBBBBB, 1, 0, 1, 0, 5'd21);
    step();
    drive(1, 24'hCCCCCC, 1, 0, 0, 0, 5'd22);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    drive(0, 24'h0, 0, 0, 0, 0, 5'd0);
    checks++; if (out_valid !== 1'b0 || out_r !== 24'h0) begin errors++; $display("FAIL flush_two got %b/%h exp 0/0", out_valid, out_r); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", in_ready); end
    checks++; if ({psw_c, psw_n, psw_z} !== 3'b010) begin errors++; $display("FAIL flush_psw got %b exp 010", {psw_c, psw_n, psw_z}); end
`ifdef ALU_RESULT_BYPASS_EN
    checks++; if (byp_valid !== 1'b0) begin errors++; $display("FAIL flush_bypass got %b exp 0", byp_valid); end
`endif
    drive(1, 24'h000023, 0, 0, 0, 0, 5'd23);
    step();
    drive(1, 24'h000024, 0, 0, 0, 0, 5'd24);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(0, 24'h0, 0, 0, 0, 0, 5'd0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_push got %b exp 0", out_valid); end
    drive(1, 24'h000025, 0, 0, 0, 0, 5'd25);
    step();
    drive(1, 24'h0, 0, 0, 0, 1, 5'd12);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(0, 24'h0, 0, 0, 0, 0, 5'd0);
    checks++; if (trap !== 1'b1 || trap_dest !== 5'd12 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_trap got %b/%0d/%b exp 1/12/0", trap, trap_dest, out_valid); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1, 24'h000030, 1, 0, 0, 0, 5'd30);
    step();
    drive(1, 24'h000031, 0, 0, 0, 0, 5'd31);
    step();
    drive(0, 24'h0, 0, 0, 0, 0, 5'd0);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_full got %b/%b exp 0/1", in_ready, out_valid); end
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_async got %b/%b exp 0/0", out_valid, in_ready); end
    checks++; if ({psw_c, psw_n, psw_z, trap} !== 4'b0) begin errors++; $display("FAIL mid_flags got %b exp 0000", {psw_c, psw_n, psw_z, trap}); end
`ifdef ALU_RESULT_BYPASS_EN
    checks++; if (byp_valid !== 1'b0) begin errors++; $display("FAIL mid_bypass got %b exp 0", byp_valid); end
`endif
    step();
    rst = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_release got %b/%b exp 1/0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_flags();
    test_error();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
